// File: rtl/toy_frame_pkg.sv
// Shared framing definitions for the packer and the descriptor parser.
// Frame on the wire: HDR, LEN, payload[LEN], CHK.
package toy_frame_pkg;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
  localparam int         LEN_W        = 8;

  typedef enum logic [2:0] {
    ST_FILL = 3'd0,
    ST_HDR  = 3'd1,
    ST_LEN  = 3'd2,
    ST_PAY  = 3'd3,
    ST_CHK  = 3'd4
  } frame_state_e;

  // CHK makes LEN + payload + CHK sum to zero mod 256.
  function automatic logic [7:0] frame_chk(
    input logic [LEN_W-1:0] len,
    input logic [7:0]       pay_sum
  );
    logic [7:0] total;
    total = len + pay_sum;
    return 8'h00 - total;
  endfunction

endpackage

// File: rtl/frame_buf.sv
// Payload store for one frame: synchronous write, asynchronous read.
// Storage is deliberately left without reset.
module frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/frame_packer.sv
// Buffers one payload frame, then emits HDR, LEN, payload and CHK.
// Outputs decode from state, so they hold steady while stalled.
module frame_packer
  import toy_frame_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF,
  parameter int         MAX_LEN  = 16,
  parameter int         PTR_W    = 4
) (
  input  logic        clk,
  input  logic        rst_a,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] frames_sent
);

  frame_state_e     state, state_d;
  logic [LEN_W-1:0] wr_cnt, wr_cnt_d;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_d;
  logic [7:0]       sum, sum_d;
  logic [15:0]      frames_d;
  logic             buf_we;
  logic [7:0]       buf_rdata;

  frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (PTR_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_cnt[PTR_W-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state       <= ST_FILL;
      wr_cnt      <= '0;
      rd_ptr      <= '0;
      sum         <= '0;
      frames_sent <= '0;
    end else begin
      state       <= state_d;
      wr_cnt      <= wr_cnt_d;
      rd_ptr      <= rd_ptr_d;
      sum         <= sum_d;
      frames_sent <= frames_d;
    end
  end

  always_comb begin
    state_d   = state;
    wr_cnt_d  = wr_cnt;
    rd_ptr_d  = rd_ptr;
    sum_d     = sum;
    frames_d  = frames_sent;
    buf_we    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    unique case (state)
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_we   = 1'b1;
          wr_cnt_d = wr_cnt + 8'd1;
          sum_d    = sum + in_data;
          // A full buffer closes the frame whatever in_last says.
          if (in_last || wr_cnt == LEN_W'(MAX_LEN - 1))
            state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        out_valid = 1'b1;
        out_data  = HDR_BYTE;
        if (out_ready) state_d = ST_LEN;
      end
      ST_LEN: begin
        out_valid = 1'b1;
        out_data  = wr_cnt;
        if (out_ready) begin
          state_d  = ST_PAY;
          rd_ptr_d = '0;
        end
      end
      ST_PAY: begin
        out_valid = 1'b1;
        out_data  = buf_rdata;
        if (out_ready) begin
          rd_ptr_d = rd_ptr + 1'b1;
          if (LEN_W'(rd_ptr) == wr_cnt - 8'd1)
            state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        out_valid = 1'b1;
        out_data  = frame_chk(wr_cnt, sum);
        if (out_ready) begin
          state_d  = ST_FILL;
          wr_cnt_d = '0;
          sum_d    = '0;
          frames_d = frames_sent + 16'd1;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  assign busy = (state != ST_FILL);

endmodule

// File: tb/tb_frame_packer.sv
// Directed and random checks of frame_packer against a byte-stream model.
module tb_frame_packer;

  logic        clk = 1'b0;
  logic        rst_a;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [15:0] frames_sent;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          got_n    = 0;
  int          rdy_mode = 0;
  int          pidx     = 0;
  logic [15:0] exp_frames = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  pay[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = 8'h00;

  frame_packer dut (
    .clk         (clk),
    .rst_a       (rst_a),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       t,
    input logic [31:0] o,
    input logic [31:0] e
  );
    n_assert++;
    if (o !== e) begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", t, o, e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_a) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'(1'b1));
        chk("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        got_n++;
        if (exp_q.size() == 0) begin
          chk("extra_byte", 32'(out_data), 32'h100);
        end else begin
          chk("stream_byte", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_mode == 1) begin
      out_ready = 1'($urandom_range(0, 1));
    end else if (rdy_mode == 2) begin
      pidx++;
      out_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
    end
  endtask

  task automatic model_frame(input int n);
    int total;
    total = n;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      total += int'(pay[i]);
      exp_q.push_back(pay[i]);
    end
    exp_q.push_back(8'((256 - (total % 256)) % 256));
    exp_frames++;
  endtask

  task automatic send_frame(
    input int n,
    input bit use_last,
    input bit gaps
  );
    int k;
    model_frame(n);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      in_data  = pay[i];
      in_valid = 1'b1;
      in_last  = use_last && (i == n - 1);
      k = 0;
      while (in_ready !== 1'b1 && k < 2000) begin
        tick();
        k++;
      end
      if (k == 2000)
        chk("in_ready_timeout", 32'(in_ready), 32'(1'b1));
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && k < 5000) begin
      tick();
      k++;
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_frames"}, 32'(frames_sent), 32'(exp_frames));
  endtask

  task automatic do_reset();
    rst_a = 1'b1;
    #1;
    exp_q.delete();
    exp_frames = 0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_frames", 32'(frames_sent), 32'h0000);
    tick();
    rst_a = 1'b0;
  endtask

  initial begin
    int base;
    int k;
    rst_a     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2;
    do_reset();
    tick();

    pay = '{8'h00};
    send_frame(1, 1'b1, 1'b0);
    chk("t1_hdr_valid", 32'(out_valid), 32'd1);
    chk("t1_hdr_data", 32'(out_data), 32'hA5);
    chk("t1_in_ready_hdr", 32'(in_ready), 32'd0);
    tick();
    tick();
    tick();
    chk("t1_chk_data", 32'(out_data), 32'hFF);
    chk("t1_in_ready_chk", 32'(in_ready), 32'd0);
    tick();
    chk("t1_in_ready_back", 32'(in_ready), 32'd1);
    chk("t1_frames", 32'(frames_sent), 32'd1);

    pay = '{8'h01, 8'h02, 8'h03};
    send_frame(3, 1'b1, 1'b0);
    chk("t2_hdr_latency", 32'(out_valid), 32'd1);
    chk("t2_hdr_data", 32'(out_data), 32'hA5);
    drain("t2");

    pay.delete();
    for (int i = 0; i < 16; i++) pay.push_back(8'hFF);
    send_frame(16, 1'b0, 1'b0);
    chk("t3_forced_close", 32'(out_valid), 32'd1);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    drain("t3");

    rdy_mode  = 2;
    pidx      = 0;
    out_ready = 1'b1;
    pay = '{8'h01, 8'h02, 8'h03};
    send_frame(3, 1'b1, 1'b0);
    drain("t4");
    rdy_mode  = 0;
    out_ready = 1'b1;

    base = got_n;
    send_frame(3, 1'b1, 1'b0);
    k = 0;
    while (got_n < base + 4 && k < 100) begin
      tick();
      k++;
    end
    chk("t5_reached_pay", 32'(got_n), 32'(base + 4));
    chk("t5_busy_pre", 32'(busy), 32'd1);
    do_reset();
    pay = '{8'hAA};
    send_frame(1, 1'b1, 1'b0);
    drain("t5");

    do_reset();
    rdy_mode = 1;
    for (int f = 0; f < 200; f++) begin
      int n;
      n = $urandom_range(1, 16);
      pay.delete();
      for (int i = 0; i < n; i++)
        pay.push_back(8'($urandom_range(0, 255)));
      send_frame(n, (n < 16) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1);
    end
    drain("rand");
    chk("rand_frames_200", 32'(frames_sent), 32'd200);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
